// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage sitting directly after the program counter. Latches the current word-addressed
//   PC, issues one instruction-memory read at a time over a req/ack handshake, and buffers each
//   returned word together with its PC in a DEPTH-entry FIFO that feeds decode via valid/ready.
//   pc_en tells the PC register to advance; flush discards wrong-path fetches and FIFO contents.
//
// Build option:
//   FETCH_PERF_CNT_EN  when defined, fetch_count / stall_count are live 32-bit wrapping
//                      counters cleared only by reset; otherwise both read 0 and no flops exist.
//
// Ports:
//   clk, reset               rising-edge clock, synchronous active-low reset
//   pc                       current PC (word address)
//   pc_en                    PC advances on the next edge (combinational, never set during flush)
//   flush                    taken branch: drop in-flight fetch and clear the FIFO
//   imem_req/addr/ack/rdata  instruction memory read handshake
//   instr/instr_pc/valid     FIFO head presented to decode; ready pops it
//   fetch_count/stall_count  performance counters
module instr_fetch_unit #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        pc_en,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

    state_e          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [63:0]     mem_q [DEPTH];   // {pc, instruction}
    logic            push;
    logic            pop;

    // Next-state and handshake decode
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        push    = 1'b0;
        pc_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Only issue when the result is guaranteed a FIFO slot.
                if (!flush && (count_q < CntW'(DEPTH))) begin
                    state_d = StReq;
                    addr_d  = pc;
                end
            end
            StReq: begin
                if (imem_ack) begin
                    state_d = StIdle;
                    push    = !flush;
                    pc_en   = !flush;
                end else if (flush) begin
                    state_d = StDrop;
                end
            end
            StDrop: begin
                // Wait out the wrong-path read; its data is discarded.
                if (imem_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign imem_req    = (state_q != StIdle);
    assign imem_addr   = addr_q;
    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid && instr_ready;

    // Storage is not reset, so gate the head to keep outputs at 0 while empty.
    assign instr    = instr_valid ? mem_q[rd_ptr_q][31:0]  : '0;
    assign instr_pc = instr_valid ? mem_q[rd_ptr_q][63:32] : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            if (flush) begin
                // Flush wins over any same-cycle pop.
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PtrW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PtrW'(1);
                end
                count_q <= count_q + CntW'(push) - CntW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_q[wr_ptr_q] <= {addr_q, imem_rdata};
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (push) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (instr_valid && !instr_ready) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
`else
    assign fetch_count = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: scoreboard of expected {pc, instr} pushed on each accepted
// memory ack and popped when decode takes the FIFO head.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pc_en;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] fetch_count;
    logic [31:0] stall_count;

    always #5 clk = ~clk;

    instr_fetch_unit #(.DEPTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .pc_en       (pc_en),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fetch_count (fetch_count),
        .stall_count (stall_count)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] sb [$];
    bit          mem_auto     = 1'b0;
    bit          mon_en       = 1'b0;
    bit          drop_pending = 1'b0;
    bit          pc_inc       = 1'b0;
    int          exp_fetch    = 0;
    int          exp_stall    = 0;
    int          pulses       = 0;
    int          pops         = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_perf();
`ifdef FETCH_PERF_CNT_EN
        check_eq("fetch_count", fetch_count, exp_fetch);
        check_eq("stall_count", stall_count, exp_stall);
`else
        check_eq("fetch_count", fetch_count, 32'd0);
        check_eq("stall_count", stall_count, 32'd0);
`endif
    endtask

    // One clock cycle; called just after a falling edge with inputs already set.
    task automatic step();
        logic [63:0] e;
        bit          has_head;
        bit          exp_en;
        if (mem_auto) begin
            imem_ack   = imem_req;
            imem_rdata = 32'h1000 + imem_addr;
        end
        #1;
        if (mon_en) begin
            has_head = (sb.size() != 0);
            check_eq("instr_valid", 32'(instr_valid), 32'(has_head));
            if (has_head && !instr_ready) exp_stall++;
            if (has_head && instr_ready) begin
                e = sb.pop_front();
                pops++;
                check_eq("instr", instr, e[31:0]);
                check_eq("instr_pc", instr_pc, e[63:32]);
            end
            exp_en = imem_req && imem_ack && !flush && !drop_pending;
            check_eq("pc_en", 32'(pc_en), 32'(exp_en));
            if (imem_req && !drop_pending) check_eq("imem_addr", imem_addr, pc);
            if (exp_en) begin
                sb.push_back({pc, 32'h1000 + pc});
                exp_fetch++;
                pulses++;
                pc_inc = 1'b1;
            end
            if (imem_req && imem_ack) drop_pending = 1'b0;
            else if (imem_req && flush) drop_pending = 1'b1;
            if (flush) sb.delete();
            if (!reset) begin
                sb.delete();
                drop_pending = 1'b0;
                exp_fetch    = 0;
                exp_stall    = 0;
                pc_inc       = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (pc_inc) begin
            pc     = pc + 32'd1;
            pc_inc = 1'b0;
        end
    endtask

    task automatic do_reset();
        mem_auto = 1'b0;
        imem_ack = 1'b0;
        flush    = 1'b0;
        reset    = 1'b0;
        step();
        step();
        reset = 1'b1;
        pc    = 32'd0;
        check_perf();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // 1: reset with ack held high
        reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1234; pc = 32'd0;
        flush = 1'b0; instr_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst imem_req", 32'(imem_req), 32'd0);
        check_eq("rst imem_addr", imem_addr, 32'd0);
        check_eq("rst pc_en", 32'(pc_en), 32'd0);
        check_eq("rst instr", instr, 32'd0);
        check_eq("rst instr_pc", instr_pc, 32'd0);
        check_eq("rst instr_valid", 32'(instr_valid), 32'd0);
        check_eq("rst fetch_count", fetch_count, 32'd0);
        check_eq("rst stall_count", stall_count, 32'd0);
        imem_ack = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("first imem_req", 32'(imem_req), 32'd1);
        check_eq("first imem_addr", imem_addr, 32'd0);

        // 2: streaming with a 1-cycle memory, one instruction every 2 cycles
        mon_en = 1'b1; mem_auto = 1'b1; pulses = 0; pops = 0;
        for (int i = 0; i < 8; i++) step();
        check_eq("stream pc_en pulses", pulses, 32'd4);
        check_eq("stream pops", pops, 32'd4);
        check_perf();

        // 3: decode stalled; FIFO fills and fetch stops
        do_reset();
        instr_ready = 1'b0; mem_auto = 1'b1;
        for (int i = 0; i < 12; i++) step();
        check_eq("stall imem_req", 32'(imem_req), 32'd0);
        check_eq("stall instr", instr, 32'h1000);
        check_eq("stall instr_pc", instr_pc, 32'd0);
        check_perf();
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // 4: flush while a request is outstanding, late ack
        do_reset();
        instr_ready = 1'b1;
        step();
        check_eq("t4 req", 32'(imem_req), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        pc    = 32'h40;
        step();
        step();
        check_eq("t4 drop req", 32'(imem_req), 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'hdeadbeef;
        step();
        imem_ack = 1'b0;
        check_eq("t4 valid after drop", 32'(instr_valid), 32'd0);
        step();
        check_eq("t4 redirect req", 32'(imem_req), 32'd1);
        check_eq("t4 redirect addr", imem_addr, 32'h40);
        imem_ack = 1'b1; imem_rdata = 32'h1040;
        step();
        imem_ack = 1'b0;
        step();
        check_perf();

        // 5: flush coincident with ack and pop
        do_reset();
        instr_ready = 1'b0;
        step();
        imem_ack = 1'b1; imem_rdata = 32'h1000;
        step();
        imem_ack = 1'b0;
        step();
        instr_ready = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1001; flush = 1'b1;
        step();
        flush = 1'b0; imem_ack = 1'b0;
        check_eq("t5 valid after flush", 32'(instr_valid), 32'd0);
        check_perf();
        step();
        step();

        // 6: reset during an outstanding request, stale ack afterwards
        do_reset();
        instr_ready = 1'b1;
        step();
        check_eq("t6 req", 32'(imem_req), 32'd1);
        reset = 1'b0;
        step();
        check_eq("t6 req after reset", 32'(imem_req), 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'h0bad; reset = 1'b1;
        step();
        imem_ack = 1'b0;
        check_eq("t6 no push", 32'(instr_valid), 32'd0);
        check_perf();
        step();
        imem_ack = 1'b1; imem_rdata = 32'h1000;
        step();
        imem_ack = 1'b0;
        step();
        step();
        check_perf();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
